// File: rtl/corelet_seq.sv
// Control sequencer for the corelet datapath: per tile, walks every kernel position through
// clear, weight load, drain, execute and flush, then SFP accumulation. Optional macro: CORELET_SEQ_2BIT_EN.
module corelet_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int kij_len = 9,
  parameter int act_len = 36,
  parameter int nij_len = 16,
  parameter int addr_bw = 11,
  parameter int tile_bw = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [tile_bw-1:0] num_tiles,
  input  logic               mode_2bit,
  input  logic               ofifo_valid,
  input  logic               ofifo_full,
  output logic               busy,
  output logic               done,
  output logic [1:0]         inst_w,
  output logic               l0_wr,
  output logic               load,
  output logic [addr_bw-1:0] w_addr,
  output logic [addr_bw-1:0] act_addr,
  output logic               ofifo_rd,
  output logic               psum_wr,
  output logic [addr_bw-1:0] psum_addr,
  output logic               acc,
  output logic [addr_bw-1:0] sfp_addr,
  output logic [2:0]         phase
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    WLOAD  = 3'd2,
    WDRAIN = 3'd3,
    EXEC   = 3'd4,
    FLUSH  = 3'd5,
    ACC    = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t             state, state_n;
  logic [addr_bw-1:0] cnt, cnt_n, kij, kij_n;
  logic [tile_bw-1:0] tile, tile_n, tiles_q, tiles_n;
  logic [tile_bw:0]   tile_inc;
  logic [addr_bw-1:0] w_len;
  logic [addr_bw-1:0] w_addr_n, act_addr_n, psum_addr_n, sfp_addr_n;
  logic [1:0]         inst_w_n;
  logic               busy_n, done_n, l0_wr_n, load_n, ofifo_rd_n, psum_wr_n, acc_n;

`ifdef CORELET_SEQ_2BIT_EN
  logic mode_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    mode_q <= 1'b0;
    else if (state == IDLE && start) mode_q <= mode_2bit;
  end

  assign w_len = mode_q ? addr_bw'(2 * row) : addr_bw'(row);
`else
  logic unused_mode;
  assign unused_mode = mode_2bit;
  assign w_len       = addr_bw'(row);
`endif

  assign tile_inc = {1'b0, tile} + 1'b1;
  assign phase    = state;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    kij_n       = kij;
    tile_n      = tile;
    tiles_n     = tiles_q;
    w_addr_n    = w_addr;
    act_addr_n  = act_addr;
    sfp_addr_n  = sfp_addr;
    psum_addr_n = psum_wr ? psum_addr + 1'b1 : psum_addr;

    case (state)
      IDLE: if (start) begin
        state_n     = CLEAR;
        kij_n       = '0;
        tile_n      = '0;
        psum_addr_n = '0;
        w_addr_n    = '0;
        tiles_n     = (num_tiles == '0) ? tile_bw'(1) : num_tiles;
      end
      CLEAR: begin
        state_n    = WLOAD;
        cnt_n      = '0;
        act_addr_n = '0;
      end
      WLOAD: begin
        w_addr_n = w_addr + 1'b1;
        if (cnt == w_len - 1'b1) begin
          state_n = WDRAIN;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      WDRAIN: begin
        if (cnt == addr_bw'(col - 1)) begin
          state_n = EXEC;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      // Only cycles that actually issued an execute count toward act_len.
      EXEC: if (inst_w == 2'b10) begin
        act_addr_n = act_addr + 1'b1;
        if (cnt == addr_bw'(act_len - 1)) begin
          state_n = FLUSH;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      FLUSH: begin
        if (cnt < addr_bw'(row + col - 1)) cnt_n = cnt + 1'b1;
        else if (!ofifo_valid) begin
          cnt_n      = '0;
          kij_n      = kij + 1'b1;
          sfp_addr_n = '0;
          state_n    = ((kij + 1'b1) < addr_bw'(kij_len)) ? CLEAR : ACC;
        end
      end
      ACC: begin
        if (sfp_addr == addr_bw'(nij_len - 1)) begin
          tile_n = tile_inc[tile_bw-1:0];
          if (tile_inc < {1'b0, tiles_q}) begin
            state_n     = CLEAR;
            kij_n       = '0;
            psum_addr_n = '0;
            w_addr_n    = '0;
          end else state_n = DONE;
        end else sfp_addr_n = sfp_addr + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Output strobes are decoded from the state being entered so they register alongside phase.
    inst_w_n = 2'b00;
    l0_wr_n  = 1'b0;
    load_n   = 1'b0;
    acc_n    = 1'b0;
    done_n   = 1'b0;
    case (state_n)
      CLEAR: load_n = 1'b1;
      WLOAD: begin
        l0_wr_n  = 1'b1;
        inst_w_n = 2'b01;
      end
      EXEC: if (!ofifo_full) begin
        l0_wr_n  = 1'b1;
        inst_w_n = 2'b10;
      end
      ACC:     acc_n  = 1'b1;
      DONE:    done_n = 1'b1;
      default: ;
    endcase
    busy_n     = (state_n != IDLE) && (state_n != DONE);
    ofifo_rd_n = ofifo_valid && (state_n != IDLE);
    psum_wr_n  = ofifo_valid && (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      kij       <= '0;
      tile      <= '0;
      tiles_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      inst_w    <= 2'b00;
      l0_wr     <= 1'b0;
      load      <= 1'b0;
      w_addr    <= '0;
      act_addr  <= '0;
      ofifo_rd  <= 1'b0;
      psum_wr   <= 1'b0;
      psum_addr <= '0;
      acc       <= 1'b0;
      sfp_addr  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      kij       <= kij_n;
      tile      <= tile_n;
      tiles_q   <= tiles_n;
      busy      <= busy_n;
      done      <= done_n;
      inst_w    <= inst_w_n;
      l0_wr     <= l0_wr_n;
      load      <= load_n;
      w_addr    <= w_addr_n;
      act_addr  <= act_addr_n;
      ofifo_rd  <= ofifo_rd_n;
      psum_wr   <= psum_wr_n;
      psum_addr <= psum_addr_n;
      acc       <= acc_n;
      sfp_addr  <= sfp_addr_n;
    end
  end

endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: each job pushes its expected summary, a monitor measures
// the DUT's control stream and compares when done pulses.
module tb_corelet_seq;

  localparam int ROW = 8, COL = 8, KIJ = 9, ACT = 36, NIJ = 16, AW = 11, TW = 4;
`ifdef CORELET_SEQ_2BIT_EN
  localparam int W_2BIT = 2 * ROW;
`else
  localparam int W_2BIT = ROW;
`endif

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, mode_2bit = 1'b0;
  logic          ofifo_valid = 1'b0, ofifo_full = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic          busy, done, l0_wr, load, ofifo_rd, psum_wr, acc;
  logic [1:0]    inst_w;
  logic [AW-1:0] w_addr, act_addr, psum_addr, sfp_addr;
  logic [2:0]    phase;

  int checks = 0, failures = 0;

  corelet_seq dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles), .mode_2bit(mode_2bit),
    .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full), .busy(busy), .done(done),
    .inst_w(inst_w), .l0_wr(l0_wr), .load(load), .w_addr(w_addr), .act_addr(act_addr),
    .ofifo_rd(ofifo_rd), .psum_wr(psum_wr), .psum_addr(psum_addr), .acc(acc),
    .sfp_addr(sfp_addr), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int cycles;       // index of the done cycle, the start cycle being cycle 1
    int acc_beats;
    int bursts;
    int exec_max;
    int stalls;
    int flush_max;
    int wload_len;
    int w_end;
    int act_end;
    int psum_writes;
    int tile_psum;
    int proto_errs;
  } job_t;

  job_t exp_q[$];
  job_t obs, blank, exp_job;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic timeout_fail(input string what);
    checks++;
    failures++;
    $display("FAIL timeout %s: event not seen within budget", what);
    finish_tb();
  endtask

  function automatic job_t mk_exp(input string tag, input int tiles, input int w,
                                  input int stalls, input int flush_extra, input int writes);
    job_t e;
    int per_kij;
    per_kij       = 1 + w + COL + ACT + ROW + COL;
    e.tag         = tag;
    e.cycles      = 1 + tiles * (KIJ * per_kij + NIJ) + stalls + flush_extra + 1;
    e.acc_beats   = NIJ * tiles;
    e.bursts      = tiles;
    e.exec_max    = ACT + stalls;
    e.stalls      = stalls;
    e.flush_max   = ROW + COL + flush_extra;
    e.wload_len   = w;
    e.w_end       = KIJ * w;
    e.act_end     = ACT;
    e.psum_writes = writes;
    e.tile_psum   = 0;
    e.proto_errs  = 0;
    return e;
  endfunction

  // Monitor: measures each job from its first CLEAR cycle and scores it on done.
  logic [2:0] prev_phase = 3'd0;
  logic       in_job = 1'b0;
  int         run_len = 0, acc_run = 0;

  always @(negedge clk) begin
    if (!reset) begin
      in_job  = 1'b0;
      run_len = 0;
      acc_run = 0;
    end else begin
      if (!in_job && prev_phase == 3'd0 && phase == 3'd1) begin
        in_job     = 1'b1;
        obs        = blank;
        obs.cycles = 1;
      end
      if (in_job) begin
        obs.cycles++;
        run_len = (phase == prev_phase) ? run_len + 1 : 1;
        if (busy !== (phase >= 3'd1 && phase <= 3'd6)) obs.proto_errs++;
        if (done !== (phase == 3'd7)) obs.proto_errs++;
        if (load !== (phase == 3'd1)) obs.proto_errs++;
        if (acc !== (phase == 3'd6)) obs.proto_errs++;
        if (ofifo_rd !== psum_wr) obs.proto_errs++;
        if (psum_wr) obs.psum_writes++;
        if (phase != 3'd2 && phase != 3'd4 && (inst_w != 2'b00 || l0_wr)) obs.proto_errs++;
        case (phase)
          3'd1: if ((prev_phase == 3'd0 || prev_phase == 3'd6) && int'(psum_addr) > obs.tile_psum)
                  obs.tile_psum = int'(psum_addr);
          3'd2: begin
            obs.wload_len = run_len;
            if (inst_w != 2'b01 || !l0_wr) obs.proto_errs++;
          end
          3'd4: begin
            if (run_len > obs.exec_max) obs.exec_max = run_len;
            if (inst_w == 2'b00 && !l0_wr) obs.stalls++;
            else if (!(inst_w == 2'b10 && l0_wr)) obs.proto_errs++;
          end
          3'd5: begin
            if (run_len > obs.flush_max) obs.flush_max = run_len;
            if (prev_phase == 3'd4) obs.act_end = int'(act_addr);
          end
          3'd6: begin
            if (int'(sfp_addr) != acc_run) obs.proto_errs++;
            if (prev_phase != 3'd6) obs.bursts++;
            obs.acc_beats++;
            obs.w_end = int'(w_addr);
          end
          default: ;
        endcase
        acc_run = (phase == 3'd6) ? acc_run + 1 : 0;
        if (done) begin
          in_job = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: done seen with no job queued, want no done");
          end else begin
            exp_job = exp_q.pop_front();
            check({exp_job.tag, ".cycles"},      obs.cycles,      exp_job.cycles);
            check({exp_job.tag, ".acc_beats"},   obs.acc_beats,   exp_job.acc_beats);
            check({exp_job.tag, ".acc_bursts"},  obs.bursts,      exp_job.bursts);
            check({exp_job.tag, ".exec_len"},    obs.exec_max,    exp_job.exec_max);
            check({exp_job.tag, ".stalls"},      obs.stalls,      exp_job.stalls);
            check({exp_job.tag, ".flush_len"},   obs.flush_max,   exp_job.flush_max);
            check({exp_job.tag, ".wload_len"},   obs.wload_len,   exp_job.wload_len);
            check({exp_job.tag, ".w_addr_end"},  obs.w_end,       exp_job.w_end);
            check({exp_job.tag, ".act_addr_end"},obs.act_end,     exp_job.act_end);
            check({exp_job.tag, ".psum_writes"}, obs.psum_writes, exp_job.psum_writes);
            check({exp_job.tag, ".tile_psum"},   obs.tile_psum,   exp_job.tile_psum);
            check({exp_job.tag, ".protocol"},    obs.proto_errs,  exp_job.proto_errs);
          end
        end
      end
    end
    prev_phase = phase;
  end

  task automatic start_job(input int tiles, input logic m);
    num_tiles = TW'(tiles);
    mode_2bit = m;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string what);
    bit seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) timeout_fail({what, ".done"});
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_phase(input logic [2:0] p, input bit want_eq, input string what);
    bit ok = ((phase == p) == want_eq);
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = ((phase == p) == want_eq);
    end
    if (!ok) timeout_fail(what);
  endtask

  task automatic check_all_zero(input string what);
    check({what, ".strobes"}, int'({busy, done, inst_w, l0_wr, load, ofifo_rd, psum_wr, acc}), 0);
    check({what, ".addrs"},   int'(w_addr | act_addr | psum_addr | sfp_addr), 0);
    check({what, ".phase"},   int'(phase), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single tile, no back-pressure, nothing in the OFIFO.
    exp_q.push_back(mk_exp("plain", 1, ROW, 0, 0, 0));
    start_job(1, 1'b0);
    wait_done("plain");

    // Five cycles of ofifo_full in the middle of the first EXEC.
    exp_q.push_back(mk_exp("stall", 1, ROW, 5, 0, 0));
    start_job(1, 1'b0);
    wait_phase(3'd4, 1'b1, "stall.exec");
    repeat (3) @(negedge clk);
    ofifo_full = 1'b1;
    repeat (5) @(negedge clk);
    ofifo_full = 1'b0;
    wait_done("stall");

    // ofifo_valid held 20 cycles from FLUSH entry: FLUSH stretches to 21 cycles, 20 writes.
    exp_q.push_back(mk_exp("flush_hold", 1, ROW, 0, 5, 20));
    start_job(1, 1'b0);
    wait_phase(3'd5, 1'b1, "flush_hold.flush");
    ofifo_valid = 1'b1;
    repeat (20) @(negedge clk);
    ofifo_valid = 1'b0;
    wait_done("flush_hold");

    // Three tiles, three writes per FLUSH, one stray start pulse mid-job.
    exp_q.push_back(mk_exp("tiles3", 3, ROW, 0, 0, 3 * KIJ * 3));
    start_job(3, 1'b0);
    for (int k = 0; k < 3 * KIJ; k++) begin
      wait_phase(3'd5, 1'b1, "tiles3.flush");
      ofifo_valid = 1'b1;
      repeat (3) @(negedge clk);
      ofifo_valid = 1'b0;
      if (k == 10) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_phase(3'd5, 1'b0, "tiles3.flush_exit");
    end
    wait_done("tiles3");

    // 2-bit weight mode request.
    exp_q.push_back(mk_exp("mode2", 1, W_2BIT, 0, 0, 0));
    start_job(1, 1'b1);
    wait_done("mode2");

    // Asynchronous reset in the fourth EXEC (kij=3) once act_addr reaches 12.
    begin : reset_mid
      int         n_exec;
      bit         hit;
      logic [2:0] last;
      n_exec = 0;
      hit    = 1'b0;
      last   = 3'd1;
      start_job(1, 1'b0);
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk);
        if (phase == 3'd4 && last != 3'd4) n_exec++;
        if (n_exec == 4 && phase == 3'd4 && act_addr == AW'(12)) hit = 1'b1;
        last = phase;
      end
      if (!hit) timeout_fail("reset_mid.exec");
      reset = 1'b0;
      #1;
      check_all_zero("reset_mid");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
    end

    // Fresh job after the abort, num_tiles=0 behaving as one tile.
    exp_q.push_back(mk_exp("fresh_tiles0", 1, ROW, 0, 0, 0));
    start_job(0, 1'b0);
    wait_done("fresh_tiles0");

    check("scoreboard.pending", exp_q.size(), 0);
    finish_tb();
  end

  initial begin
    #2000000;
    timeout_fail("global");
  end

endmodule
